// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Writeback arbiter and write-port sequencer for the integer register file.
// NSRC writeback sources share one register-file write port. A round-robin
// pointer decides the grant, and the granted write is registered once before
// it reaches the register file. While that registered write is still in flight
// (not yet visible on the raw read ports), a bypass path forwards it to the
// decode operands.
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int XLEN = 64,
    parameter int NSRC = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 wb_en,
    input  logic [NSRC-1:0]      src_valid,
    output logic [NSRC-1:0]      src_ready,
    input  logic [NSRC*5-1:0]    src_rd,
    input  logic [NSRC*XLEN-1:0] src_wd,
    output logic                 rf_we,
    output logic [4:0]           rf_rd,
    output logic [XLEN-1:0]      rf_wd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [XLEN-1:0]      rf_rd1,
    input  logic [XLEN-1:0]      rf_rd2,
    output logic [XLEN-1:0]      fwd_rd1,
    output logic [XLEN-1:0]      fwd_rd2
);

    // Pointer width. It is wide enough to hold any source index 0..NSRC-1.
    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

    // Round-robin state and the registered write-port outputs.
    logic [PW-1:0]   r_ptr;
    logic            r_we;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_wd;

    // Grant decision and the write selected from the granted source.
    logic [PW-1:0]   w_gnt_idx;
    logic            w_gnt_any;
    logic            w_xfer;
    logic [4:0]      w_gnt_rd;
    logic [XLEN-1:0] w_gnt_wd;

    // Returns (base + k) modulo NSRC, for 0 <= base < NSRC and 1 <= k <= NSRC.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NSRC) begin
            sum = sum - NSRC;
        end
        return PW'(sum);
    endfunction

    // Search for the first valid source, starting at ptr+1 and wrapping around.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_gnt_idx = '0;
        w_gnt_any = 1'b0;
        for (int k = 1; k <= NSRC; k++) begin
            if (!w_gnt_any && src_valid[wrap_add(r_ptr, k)]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = wrap_add(r_ptr, k);
            end
        end
    end

    // A grant is only issued when writeback is enabled and reset is not
    // asserted. The granted source is valid by construction, so any grant is
    // also a transfer.
    assign w_xfer = w_gnt_any && wb_en && resetn;

    // One-hot ready vector. It depends only on valid, wb_en and ptr (and on
    // reset).
    always_comb begin
        src_ready = '0;
        if (w_xfer) begin
            src_ready[w_gnt_idx] = 1'b1;
        end
    end

    // Select the destination register and the data of the granted source.
    always_comb begin
        w_gnt_rd = src_rd[5*int'(w_gnt_idx) +: 5];
        w_gnt_wd = src_wd[XLEN*int'(w_gnt_idx) +: XLEN];
    end

    // Advance the round-robin pointer to the most recently granted source.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ptr <= PW'(NSRC - 1);
        end else if (w_xfer) begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // always_ff block samples the values from before the edge.
            r_ptr <= w_gnt_idx;
        end
    end

    // Register the granted write. A write to x0 uses the slot but does not
    // raise the write enable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_we <= 1'b0;
            r_rd <= '0;
            r_wd <= '0;
        end else if (w_xfer) begin
            r_we <= (w_gnt_rd != 5'd0);
            r_rd <= w_gnt_rd;
            r_wd <= w_gnt_wd;
        end else begin
            r_we <= 1'b0;
        end
    end

    assign rf_we = r_we;
    assign rf_rd = r_rd;
    assign rf_wd = r_wd;

    // Forward the in-flight write to the decode operands. x0 is never
    // forwarded.
    always_comb begin
        fwd_rd1 = (r_we && (r_rd == rs1) && (rs1 != 5'd0)) ? r_wd : rf_rd1;
        fwd_rd2 = (r_we && (r_rd == rs2) && (rs2 != 5'd0)) ? r_wd : rf_rd2;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed bench for wb_arbiter (XLEN=64, NSRC=3). Every expected value is
// worked out by hand. Inputs change 1 ns after the rising edge. Outputs are
// sampled 1-2 ns after that, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int XLEN = 64;
    localparam int NSRC = 3;

    logic                 clk;
    logic                 resetn;
    logic                 wb_en;
    logic [NSRC-1:0]      src_valid;
    logic [NSRC-1:0]      src_ready;
    logic [NSRC*5-1:0]    src_rd;
    logic [NSRC*XLEN-1:0] src_wd;
    logic                 rf_we;
    logic [4:0]           rf_rd;
    logic [XLEN-1:0]      rf_wd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [XLEN-1:0]      rf_rd1;
    logic [XLEN-1:0]      rf_rd2;
    logic [XLEN-1:0]      fwd_rd1;
    logic [XLEN-1:0]      fwd_rd2;

    int n_checks = 0;
    int n_errors = 0;

    wb_arbiter #(.XLEN(XLEN), .NSRC(NSRC)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .wb_en     (wb_en),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_rd    (src_rd),
        .src_wd    (src_wd),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wd     (rf_wd),
        .rs1       (rs1),
        .rs2       (rs2),
        .rf_rd1    (rf_rd1),
        .rf_rd2    (rf_rd2),
        .fwd_rd1   (fwd_rd1),
        .fwd_rd2   (fwd_rd2)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if it does not match.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait until 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load the destination register and data for one source.
    task automatic set_src(input int i, input logic [4:0] rd, input logic [63:0] wd);
        src_rd[5*i +: 5]       = rd;
        src_wd[XLEN*i +: XLEN] = wd;
    endtask

    // Assert reset across one rising edge, then release it mid-cycle.
    task automatic do_reset();
        resetn    = 1'b0;
        src_valid = '0;
        @(posedge clk);
        #3;
        resetn = 1'b1;
    endtask

    logic [2:0] exp_order [6];
    logic [4:0] exp_rd    [3];

    initial begin
        resetn    = 1'b0;
        wb_en     = 1'b1;
        src_valid = 3'b111;
        src_rd    = '0;
        src_wd    = '0;
        rs1       = 5'd5;
        rs2       = 5'd0;
        rf_rd1    = 64'h11;
        rf_rd2    = 64'h22;
        #2;
        // Reset values. A request present during reset must not be granted.
        check("reset_rf_we",   64'(rf_we),     64'd0);
        check("reset_rf_rd",   64'(rf_rd),     64'd0);
        check("reset_rf_wd",   rf_wd,          64'd0);
        check("reset_ready",   64'(src_ready), 64'd0);
        check("reset_fwd_rd1", fwd_rd1,        64'h11);
        check("reset_fwd_rd2", fwd_rd2,        64'h22);
        src_valid = '0;
        @(posedge clk);
        #3;
        resetn = 1'b1;

        // 1. Single source
        tick();
        check("deassert_no_we", 64'(rf_we), 64'd0);
        set_src(0, 5'd5, 64'hAA);
        src_valid = 3'b001;
        #1;
        check("single_ready", 64'(src_ready), 64'b001);
        tick();
        src_valid = '0;
        check("single_we", 64'(rf_we), 64'd1);
        check("single_rd", 64'(rf_rd), 64'd5);
        check("single_wd", rf_wd,      64'hAA);
        tick();
        check("single_we_drop", 64'(rf_we), 64'd0);
        check("single_rd_hold", 64'(rf_rd), 64'd5);
        check("single_wd_hold", rf_wd,      64'hAA);

        // 2. Round robin from reset: the order must be 0,1,2,0,1,2
        do_reset();
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_rd    = '{5'd1, 5'd2, 5'd3};
        set_src(0, 5'd1, 64'h100);
        set_src(1, 5'd2, 64'h200);
        set_src(2, 5'd3, 64'h300);
        tick();
        src_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("rr_ready_%0d", c), 64'(src_ready), 64'(exp_order[c]));
            tick();
            check($sformatf("rr_we_%0d", c), 64'(rf_we), 64'd1);
            check($sformatf("rr_rd_%0d", c), 64'(rf_rd), 64'(exp_rd[c % 3]));
        end
        src_valid = '0;
        tick();
        check("rr_we_end", 64'(rf_we), 64'd0);

        // 3. x0 write: the pointer is now 2, so source 1 is granted from its
        //    request alone. The next search starts at 2.
        set_src(1, 5'd0, 64'hFF);
        src_valid = 3'b010;
        #1;
        check("x0_ready", 64'(src_ready), 64'b010);
        tick();
        check("x0_we",  64'(rf_we), 64'd0);
        check("x0_rd",  64'(rf_rd), 64'd0);
        check("x0_wd",  rf_wd,      64'hFF);
        src_valid = 3'b111;
        #1;
        check("x0_next_ready", 64'(src_ready), 64'b100);
        tick();
        src_valid = '0;
        check("x0_next_we", 64'(rf_we), 64'd1);
        check("x0_next_rd", 64'(rf_rd), 64'd3);

        // 4. Bypass: the pointer is 2, so source 0 gets the write of x7.
        set_src(0, 5'd7, 64'h1234);
        src_valid = 3'b001;
        tick();
        src_valid = '0;
        rs1    = 5'd7;
        rs2    = 5'd8;
        rf_rd1 = 64'h0;
        rf_rd2 = 64'h55;
        #1;
        check("byp_fwd_rd1", fwd_rd1, 64'h1234);
        check("byp_fwd_rd2", fwd_rd2, 64'h55);
        rs1    = 5'd0;
        rf_rd1 = 64'h99;
        rs2    = 5'd7;
        #1;
        check("byp_x0_rd1",  fwd_rd1, 64'h99);
        check("byp_rs2_hit", fwd_rd2, 64'h1234);
        tick();
        rs1 = 5'd7;
        #1;
        check("byp_expired", fwd_rd1, 64'h99);

        // 5. Freeze: the pointer is 0, so source 2 is granted. A three-cycle
        //    freeze follows, and then source 0 must come next.
        set_src(0, 5'd10, 64'hA0);
        set_src(2, 5'd12, 64'hC0);
        src_valid = 3'b101;
        #1;
        check("frz_pre_ready", 64'(src_ready), 64'b100);
        tick();
        wb_en = 1'b0;
        #1;
        check("frz_inflight_we", 64'(rf_we), 64'd1);
        check("frz_inflight_rd", 64'(rf_rd), 64'd12);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("frz_ready_%0d", c), 64'(src_ready), 64'd0);
            tick();
            check($sformatf("frz_we_%0d", c), 64'(rf_we), 64'd0);
        end
        wb_en = 1'b1;
        #1;
        check("frz_resume_0", 64'(src_ready), 64'b001);
        tick();
        check("frz_resume_rd", 64'(rf_rd), 64'd10);
        #1;
        check("frz_resume_1", 64'(src_ready), 64'b100);
        tick();
        src_valid = '0;

        // 6. Reset mid-write: the pointer is 2, so source 1 is granted. Reset
        //    is then pulsed in the following cycle.
        set_src(1, 5'd9, 64'h77);
        src_valid = 3'b010;
        #1;
        check("rst_grant", 64'(src_ready), 64'b010);
        tick();
        src_valid = '0;
        check("rst_pre_we", 64'(rf_we), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_async_we", 64'(rf_we), 64'd0);
        check("rst_async_rd", 64'(rf_rd), 64'd0);
        @(posedge clk);
        #3;
        resetn = 1'b1;
        #1;
        check("rst_release_we", 64'(rf_we), 64'd0);
        src_valid = 3'b111;
        #1;
        check("rst_prio_src0", 64'(src_ready), 64'b001);
        tick();
        src_valid = '0;
        check("rst_post_rd", 64'(rf_rd), 64'd10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
